uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: configurable 5..8 data bits, optional parity, 1/2 stop bits.
// Frame configuration is captured at accept and held until the frame ends.
module uart_tx #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] baud_count,
    input  logic [3:0]       data_bits,
    input  logic             parity_en,
    input  logic             odd_parity,
    input  logic             two_stop,
    input  logic [7:0]       tx_data,
    input  logic             tx_data_valid,
    output logic             tx_data_ready,
    output logic             tx,
    output logic             tx_busy,
    output logic             tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] period_q, period_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic             stop_idx, stop_idx_n;
    logic [7:0]       sh, sh_n;
    logic [7:0]       data_q, data_n;
    logic [3:0]       nbits_q, nbits_n;
    logic             par_en_q, par_en_n;
    logic             odd_q, odd_n;
    logic             two_q, two_n;
    logic             tx_q, tx_n;

    logic [3:0]       nb_in;
    logic [7:0]       mask;
    logic [CNT_W-1:0] period_in;
    logic             last_period;
    logic             last_bit;
    logic             par_bit;

    assign nb_in       = (data_bits >= 4'd5 && data_bits <= 4'd8) ? data_bits : 4'd8;
    assign mask        = 8'hFF >> (4'd8 - nb_in);
    assign period_in   = (baud_count == '0) ? CNT_W'(1) : baud_count;
    assign last_period = (cnt == CNT_W'(1));
    assign last_bit    = ({1'b0, bit_idx} == nbits_q - 4'd1);
    // data_q holds only the bits actually sent, so a full reduction is correct
    assign par_bit     = (^data_q) ^ odd_q;

    assign tx_data_ready = (state == IDLE) && !rst;
    assign tx_busy       = (state != IDLE);
    assign tx_done       = (state == STOP) && last_period && (!two_q || stop_idx);
    assign tx            = tx_q;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        period_n   = period_q;
        bit_idx_n  = bit_idx;
        stop_idx_n = stop_idx;
        sh_n       = sh;
        data_n     = data_q;
        nbits_n    = nbits_q;
        par_en_n   = par_en_q;
        odd_n      = odd_q;
        two_n      = two_q;
        tx_n       = tx_q;
        unique case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (tx_data_valid) begin
                    state_n    = START;
                    cnt_n      = period_in;
                    period_n   = period_in;
                    bit_idx_n  = 3'd0;
                    stop_idx_n = 1'b0;
                    sh_n       = tx_data & mask;
                    data_n     = tx_data & mask;
                    nbits_n    = nb_in;
                    par_en_n   = parity_en;
                    odd_n      = odd_parity;
                    two_n      = two_stop;
                    tx_n       = 1'b0;
                end
            end
            START: begin
                if (last_period) begin
                    state_n = DATA;
                    cnt_n   = period_q;
                    tx_n    = sh[0];
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            DATA: begin
                if (last_period) begin
                    cnt_n = period_q;
                    if (last_bit) begin
                        if (par_en_q) begin
                            state_n = PARITY;
                            tx_n    = par_bit;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        sh_n      = sh >> 1;
                        tx_n      = sh[1];
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            PARITY: begin
                if (last_period) begin
                    state_n = STOP;
                    cnt_n   = period_q;
                    tx_n    = 1'b1;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            STOP: begin
                tx_n = 1'b1;
                if (last_period) begin
                    if (two_q && !stop_idx) begin
                        stop_idx_n = 1'b1;
                        cnt_n      = period_q;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            period_q <= '0;
            bit_idx  <= 3'd0;
            stop_idx <= 1'b0;
            sh       <= 8'd0;
            data_q   <= 8'd0;
            nbits_q  <= 4'd0;
            par_en_q <= 1'b0;
            odd_q    <= 1'b0;
            two_q    <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            period_q <= period_n;
            bit_idx  <= bit_idx_n;
            stop_idx <= stop_idx_n;
            sh       <= sh_n;
            data_q   <= data_n;
            nbits_q  <= nbits_n;
            par_en_q <= par_en_n;
            odd_q    <= odd_n;
            two_q    <= two_n;
            tx_q     <= tx_n;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: per-cycle line waveform from a scoreboard queue.
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] baud_count = 32'd4;
    logic [3:0]  data_bits = 4'd8;
    logic        parity_en = 1'b0;
    logic        odd_parity = 1'b0;
    logic        two_stop = 1'b0;
    logic [7:0]  tx_data = 8'd0;
    logic        tx_data_valid = 1'b0;
    logic        tx_data_ready;
    logic        tx;
    logic        tx_busy;
    logic        tx_done;

    int n_pass = 0;
    int n_chk  = 0;
    logic exp_q[$];

    uart_tx #(.CNT_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .baud_count(baud_count),
        .data_bits(data_bits),
        .parity_en(parity_en),
        .odd_parity(odd_parity),
        .two_stop(two_stop),
        .tx_data(tx_data),
        .tx_data_valid(tx_data_valid),
        .tx_data_ready(tx_data_ready),
        .tx(tx),
        .tx_busy(tx_busy),
        .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    // Reference model: appends the expected per-cycle line level of one frame.
    function automatic int push_frame(input logic [7:0] d, input logic [3:0] nb,
                                      input logic pe, input logic od,
                                      input logic ts, input logic [31:0] bc);
        int p, n, len;
        logic bits[$];
        logic par;
        p = (bc == 0) ? 1 : int'(bc);
        n = (nb >= 5 && nb <= 8) ? int'(nb) : 8;
        par = od;
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            bits.push_back(d[i]);
            par = par ^ d[i];
        end
        if (pe) bits.push_back(par);
        bits.push_back(1'b1);
        if (ts) bits.push_back(1'b1);
        len = 0;
        foreach (bits[i]) begin
            for (int k = 0; k < p; k++) begin
                exp_q.push_back(bits[i]);
                len++;
            end
        end
        return len;
    endfunction

    task automatic chk(input string name, input logic act, input logic req);
        n_chk++;
        if (act !== req) $display("FAIL %s: got %b expected %b", name, act, req);
        else n_pass++;
    endtask

    task automatic wait_ready(input string name);
        int guard;
        guard = 0;
        while (tx_data_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        n_chk++;
        if (guard >= 200) $display("FAIL %s_ready_timeout: got %b expected 1", name, tx_data_ready);
        else n_pass++;
    endtask

    task automatic send_frame(input string name, input logic [7:0] d, input logic [3:0] nb,
                              input logic pe, input logic od, input logic ts,
                              input logic [31:0] bc, input bit disturb);
        int len, line_err, done_cnt;
        logic e;
        @(negedge clk);
        tx_data = d; data_bits = nb; parity_en = pe;
        odd_parity = od; two_stop = ts; baud_count = bc;
        tx_data_valid = 1'b1;
        wait_ready(name);
        len = push_frame(d, nb, pe, od, ts, bc);
        @(posedge clk);
        #1;
        tx_data_valid = 1'b0;
        if (disturb) begin
            baud_count = 32'd9; data_bits = 4'd5; parity_en = ~pe;
            two_stop = ~ts; tx_data = ~d; odd_parity = ~od;
        end
        line_err = 0;
        done_cnt = 0;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            if (tx !== e) begin
                line_err++;
                $display("FAIL %s_tx cycle %0d: got %b expected %b", name, k + 1, tx, e);
            end
            if (tx_busy !== 1'b1) begin
                line_err++;
                $display("FAIL %s_busy cycle %0d: got %b expected 1", name, k + 1, tx_busy);
            end
            if (tx_done === 1'b1) done_cnt++;
            if (k == len - 1) chk({name, "_done_last"}, tx_done, 1'b1);
        end
        n_chk++;
        if (line_err == 0) n_pass++;
        n_chk++;
        if (done_cnt != 1) $display("FAIL %s_done_count: got %0d expected 1", name, done_cnt);
        else n_pass++;
        @(negedge clk);
        chk({name, "_idle_tx"}, tx, 1'b1);
        chk({name, "_idle_busy"}, tx_busy, 1'b0);
        chk({name, "_idle_ready"}, tx_data_ready, 1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tx_data_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_done", tx_done, 1'b0);
        chk("rst_ready", tx_data_ready, 1'b0);
        tx_data_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", tx_data_ready, 1'b1);
    endtask

    task automatic test_formats;
        send_frame("8n1_a5", 8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 32'd4, 1'b0);
        send_frame("8e1_a5", 8'hA5, 4'd8, 1'b1, 1'b0, 1'b0, 32'd4, 1'b0);
        send_frame("8o1_a5", 8'hA5, 4'd8, 1'b1, 1'b1, 1'b0, 32'd4, 1'b0);
        send_frame("5o2_ff", 8'hFF, 4'd5, 1'b1, 1'b1, 1'b1, 32'd2, 1'b0);
        send_frame("6e2_2d", 8'h2D, 4'd6, 1'b1, 1'b0, 1'b1, 32'd3, 1'b0);
        send_frame("bad_nb", 8'h96, 4'd3, 1'b0, 1'b0, 1'b0, 32'd1, 1'b0);
    endtask

    task automatic test_hold_config;
        send_frame("baud0_hold", 8'h00, 4'd8, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        send_frame("7o1_hold", 8'h4B, 4'd7, 1'b1, 1'b1, 1'b0, 32'd2, 1'b1);
    endtask

    task automatic test_back_to_back;
        int len1, len2, total, err, dones;
        logic e, er, ed;
        @(negedge clk);
        baud_count = 32'd1; data_bits = 4'd8; parity_en = 1'b0;
        odd_parity = 1'b0; two_stop = 1'b0;
        tx_data = 8'h01;
        tx_data_valid = 1'b1;
        wait_ready("b2b");
        len1 = push_frame(8'h01, 4'd8, 1'b0, 1'b0, 1'b0, 32'd1);
        exp_q.push_back(1'b1);
        len2 = push_frame(8'h02, 4'd8, 1'b0, 1'b0, 1'b0, 32'd1);
        total = len1 + 1 + len2;
        @(posedge clk);
        #1;
        tx_data = 8'h02;
        err = 0;
        dones = 0;
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            e  = exp_q.pop_front();
            er = (k == len1);
            ed = (k == len1 - 1) || (k == total - 1);
            if (tx !== e || tx_data_ready !== er || tx_done !== ed) begin
                err++;
                $display("FAIL b2b cycle %0d: got tx=%b ready=%b done=%b expected tx=%b ready=%b done=%b",
                         k + 1, tx, tx_data_ready, tx_done, e, er, ed);
            end
            if (tx_done === 1'b1) dones++;
            if (k == len1 + 1) tx_data_valid = 1'b0;
        end
        n_chk++;
        if (err == 0) n_pass++;
        n_chk++;
        if (dones != 2) $display("FAIL b2b_done_pulses: got %0d expected 2", dones);
        else n_pass++;
        @(negedge clk);
        chk("b2b_idle_busy", tx_busy, 1'b0);
    endtask

    task automatic test_reset_mid_frame;
        int len, err, dones;
        logic e;
        @(negedge clk);
        tx_data = 8'h5A; data_bits = 4'd8; parity_en = 1'b0;
        odd_parity = 1'b0; two_stop = 1'b0; baud_count = 32'd4;
        tx_data_valid = 1'b1;
        wait_ready("abort");
        len = push_frame(8'h5A, 4'd8, 1'b0, 1'b0, 1'b0, 32'd4);
        @(posedge clk);
        #1;
        tx_data_valid = 1'b0;
        err = 0;
        dones = 0;
        // cycles 17..20 carry data bit 3; abort in the middle of it
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            if (tx !== e) begin
                err++;
                $display("FAIL abort_tx cycle %0d: got %b expected %b", k + 1, tx, e);
            end
            if (tx_done === 1'b1) dones++;
        end
        n_chk++;
        if (err == 0) n_pass++;
        chk("abort_pre_busy", tx_busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tx", tx, 1'b1);
        chk("abort_busy", tx_busy, 1'b0);
        chk("abort_ready", tx_data_ready, 1'b0);
        if (tx_done === 1'b1) dones++;
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (tx_done === 1'b1) dones++;
            if (tx !== 1'b1) err++;
        end
        n_chk++;
        if (dones != 0 || err != 0) $display("FAIL abort_quiet: got dones=%0d errs=%0d expected 0", dones, err);
        else n_pass++;
        exp_q.delete();
        send_frame("after_abort", 8'hC3, 4'd8, 1'b1, 1'b0, 1'b0, 32'd3, 1'b0);
    endtask

    initial begin
        test_reset();
        test_formats();
        test_hold_config();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
